// File: rtl/pwl_alu_sequencer.sv
// Frame scheduler for the shared PWL synth ALU: walks enabled channels once per
// frame issuing PHASE/SWEEP0/SWEEP1/OUT micro-ops, and arbitrates CPU state writes.
module pwl_alu_sequencer #(
    parameter  int unsigned NUM_CH       = 4,
    parameter  int unsigned FRAME_CYCLES = 128,
    localparam int unsigned CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned TW           = $clog2(FRAME_CYCLES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [4*NUM_CH-1:0] sweep_rate,
    output logic                alu_valid,
    output logic [CW-1:0]       alu_ch,
    output logic [1:0]          alu_op,
    input  logic                alu_ready,
    input  logic                cfg_req,
    output logic                cfg_grant,
    output logic                frame_start,
    output logic                busy,
    output logic                overrun,
    input  logic                overrun_clr
);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    typedef enum logic [1:0] {
        OP_PHASE  = 2'd0,
        OP_SWEEP0 = 2'd1,
        OP_SWEEP1 = 2'd2,
        OP_OUT    = 2'd3
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              frame_start_q, frame_start_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] due_q, due_d;
    logic [NUM_CH-1:0] due_new;

    logic              tick;
    logic              in_issue;
    logic              xfer;
    logic              last_xfer;
    logic              pend_ok;
    logic              start;
    logic [CW-1:0]     first_ch;
    logic [CW-1:0]     next_ch;
    logic              has_next;

    always_comb begin
        tick     = enable && (timer_q == '0);
        in_issue = (state_q == S_ISSUE);
        xfer     = in_issue && alu_ready;
        pend_ok  = pending_q && enable;
    end

    always_comb begin
        timer_d = '0;
        if (enable) begin
            timer_d = (timer_q == TW'(FRAME_CYCLES - 1)) ? '0 : timer_q + 1'b1;
        end
    end

    // Lowest enabled channel of the incoming mask, and the next channel above
    // the current one in the frame's latched mask.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (ch_enable[i-1]) begin
                first_ch = CW'(i - 1);
            end
            if (mask_q[i-1] && (CW'(i - 1) > ch_q)) begin
                next_ch  = CW'(i - 1);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        due_new = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            due_new[i] = (sweep_rate[4*i +: 4] != 4'hF) &&
                         ((frame_cnt_q & ((16'd1 << sweep_rate[4*i +: 4]) - 16'd1)) == 16'd0);
        end
    end

    always_comb begin
        last_xfer = xfer && (op_q == OP_OUT) && !has_next;
        // A tick landing on the final transfer chains straight into the next frame.
        start     = (!in_issue && (tick || pend_ok)) || (last_xfer && (pend_ok || tick));
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ch_d          = ch_q;
        frame_cnt_d   = frame_cnt_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        frame_start_d = 1'b0;
        mask_d        = mask_q;
        due_d         = due_q;

        if (start) begin
            mask_d        = ch_enable;
            due_d         = due_new;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            frame_start_d = 1'b1;
            pending_d     = 1'b0;
            op_d          = OP_PHASE;
            if (ch_enable != '0) begin
                state_d = S_ISSUE;
                ch_d    = first_ch;
            end else begin
                state_d = S_IDLE;
                ch_d    = '0;
            end
        end else if (xfer) begin
            unique case (op_q)
                OP_PHASE:  op_d = due_q[ch_q] ? OP_SWEEP0 : OP_OUT;
                OP_SWEEP0: op_d = OP_SWEEP1;
                OP_SWEEP1: op_d = OP_OUT;
                OP_OUT: begin
                    op_d = OP_PHASE;
                    if (has_next) begin
                        ch_d = next_ch;
                    end else begin
                        ch_d    = '0;
                        state_d = S_IDLE;
                    end
                end
                default: op_d = OP_PHASE;
            endcase
        end

        if (tick && in_issue && !last_xfer) begin
            pending_d = 1'b1;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (tick && in_issue) begin
            overrun_d = 1'b1;
        end
        if (!enable) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_PHASE;
            ch_q          <= '0;
            timer_q       <= '0;
            frame_cnt_q   <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_start_q <= 1'b0;
            mask_q        <= '0;
            due_q         <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            ch_q          <= ch_d;
            timer_q       <= timer_d;
            frame_cnt_q   <= frame_cnt_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            frame_start_q <= frame_start_d;
            mask_q        <= mask_d;
            due_q         <= due_d;
        end
    end

    always_comb begin
        alu_valid   = (state_q == S_ISSUE);
        busy        = (state_q == S_ISSUE);
        alu_ch      = ch_q;
        alu_op      = op_q;
        frame_start = frame_start_q;
        overrun     = overrun_q;
        cfg_grant   = rst_n && cfg_req && (state_q == S_IDLE) && !tick && !pending_q;
    end

endmodule

// File: tb/tb_pwl_alu_sequencer.sv
// Directed bench for pwl_alu_sequencer: default instance for frame ordering,
// sweeps, stalls and arbitration; a short-frame instance for overrun handling.
module tb_pwl_alu_sequencer;

    logic        clk;
    logic        rst_n, enable, alu_ready, cfg_req, overrun_clr;
    logic [3:0]  ch_enable;
    logic [15:0] sweep_rate;
    logic        alu_valid, cfg_grant, frame_start, busy, overrun;
    logic [1:0]  alu_ch, alu_op;

    logic        rst_n_b, enable_b, alu_ready_b, cfg_req_b, overrun_clr_b;
    logic [3:0]  ch_enable_b;
    logic [15:0] sweep_rate_b;
    logic        alu_valid_b, cfg_grant_b, frame_start_b, busy_b, overrun_b;
    logic [1:0]  alu_ch_b, alu_op_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_fs = 0;
    int q_ch[$];
    int q_op[$];

    pwl_alu_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_enable(ch_enable),
        .sweep_rate(sweep_rate), .alu_valid(alu_valid), .alu_ch(alu_ch),
        .alu_op(alu_op), .alu_ready(alu_ready), .cfg_req(cfg_req),
        .cfg_grant(cfg_grant), .frame_start(frame_start), .busy(busy),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    pwl_alu_sequencer #(.NUM_CH(4), .FRAME_CYCLES(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .enable(enable_b), .ch_enable(ch_enable_b),
        .sweep_rate(sweep_rate_b), .alu_valid(alu_valid_b), .alu_ch(alu_ch_b),
        .alu_op(alu_op_b), .alu_ready(alu_ready_b), .cfg_req(cfg_req_b),
        .cfg_grant(cfg_grant_b), .frame_start(frame_start_b), .busy(busy_b),
        .overrun(overrun_b), .overrun_clr(overrun_clr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int c, input int o);
        q_ch.push_back(c);
        q_op.push_back(o);
    endtask

    task automatic check_op(input string tag, input int k);
        check($sformatf("%s_valid%0d", tag, k), alu_valid, 1);
        check($sformatf("%s_busy%0d", tag, k), busy, 1);
        check($sformatf("%s_ch%0d", tag, k), alu_ch, q_ch[k]);
        check($sformatf("%s_op%0d", tag, k), alu_op, q_op[k]);
        check($sformatf("%s_grant%0d", tag, k), cfg_grant, 0);
    endtask

    task automatic frame_ops(input string tag, input int first);
        for (int k = first; k < q_ch.size(); k++) begin
            check_op(tag, k);
            step();
        end
        check({tag, "_end_valid"}, alu_valid, 0);
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_grant"}, cfg_grant, cfg_req);
    endtask

    task automatic wait_frame(input string tag);
        logic prev_g;
        bit   seen;
        seen   = 1'b0;
        prev_g = 1'b0;
        for (int i = 0; i < 300; i++) begin
            prev_g = cfg_grant;
            step();
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_tick_grant"}, prev_g, 0);
            check({tag, "_period"}, cyc - last_fs, 128);
            last_fs = cyc;
        end
    endtask

    task automatic load_sweep6();
        q_ch.delete();
        q_op.delete();
        push(0, 0); push(0, 3); push(2, 0); push(2, 1); push(2, 2); push(2, 3);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; alu_ready = 1'b0; cfg_req = 1'b1; overrun_clr = 1'b0;
        ch_enable = 4'h0; sweep_rate = 16'hFFFF;
        rst_n_b = 1'b0; enable_b = 1'b0; alu_ready_b = 1'b1; cfg_req_b = 1'b0;
        overrun_clr_b = 1'b0; ch_enable_b = 4'hF; sweep_rate_b = 16'h0000;

        repeat (3) step();
        check("rst_valid", alu_valid, 0);
        check("rst_ch", alu_ch, 0);
        check("rst_op", alu_op, 0);
        check("rst_grant", cfg_grant, 0);
        check("rst_fs", frame_start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        // All four channels, no sweeps: 8 ops per frame.
        rst_n = 1'b1; enable = 1'b1; ch_enable = 4'hF; sweep_rate = 16'hFFFF; alu_ready = 1'b1;
        #1;
        check("f1_tick_grant", cfg_grant, 0);
        step();
        check("f1_fs", frame_start, 1);
        last_fs = cyc;
        q_ch.delete();
        q_op.delete();
        for (int c = 0; c < 4; c++) begin
            push(c, 0);
            push(c, 3);
        end
        frame_ops("f1", 0);
        check("f1_fs_drop", frame_start, 0);
        wait_frame("f2");
        frame_ops("f2", 0);

        // Channels 0 and 2, ch2 rate 1: sweeps on even frame_cnt only.
        ch_enable = 4'b0101;
        sweep_rate = 16'hF1FF;
        load_sweep6();
        wait_frame("f3");
        frame_ops("f3", 0);

        q_ch.delete();
        q_op.delete();
        push(0, 0); push(0, 3); push(2, 0); push(2, 3);
        wait_frame("f4");
        frame_ops("f4", 0);

        // Stall the second op for three cycles.
        load_sweep6();
        wait_frame("f5");
        check_op("f5", 0);
        step();
        check_op("f5", 1);
        alu_ready = 1'b0;
        repeat (3) begin
            step();
            check_op("f5_hold", 1);
        end
        alu_ready = 1'b1;
        frame_ops("f5", 1);
        check("f5_no_overrun", overrun, 0);

        // Empty frame still pulses frame_start and counts.
        ch_enable = 4'h0;
        wait_frame("f6");
        check("f6_valid", alu_valid, 0);
        check("f6_busy", busy, 0);
        check("f6_grant", cfg_grant, 1);
        step();
        check("f6_fs_drop", frame_start, 0);
        check("f6_valid2", alu_valid, 0);

        // frame_cnt=6 here (even) only if the empty frame counted.
        ch_enable = 4'b0101;
        load_sweep6();
        wait_frame("f7");
        check_op("f7", 0);
        step();
        check_op("f7", 1);
        step();
        check_op("f7", 2);
        rst_n = 1'b0;
        step();
        check("mrst_valid", alu_valid, 0);
        check("mrst_ch", alu_ch, 0);
        check("mrst_op", alu_op, 0);
        check("mrst_fs", frame_start, 0);
        check("mrst_busy", busy, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_grant", cfg_grant, 0);
        rst_n = 1'b1; enable = 1'b0; cfg_req = 1'b0;

        // Short frames, every sweep due: 16 ops per frame, stalled into overrun.
        rst_n_b = 1'b1; enable_b = 1'b1; alu_ready_b = 1'b1;
        step();
        check("b_fs1", frame_start_b, 1);
        check("b_valid1", alu_valid_b, 1);
        check("b_ch1", alu_ch_b, 0);
        check("b_op1", alu_op_b, 0);
        alu_ready_b = 1'b0;
        for (int k = 2; k <= 21; k++) begin
            step();
            if (k == 16) check("b_ovr_pre", overrun_b, 0);
            if (k == 17) begin
                check("b_ovr_set", overrun_b, 1);
                check("b_no_fs", frame_start_b, 0);
            end
        end
        check("b_hold_valid", alu_valid_b, 1);
        check("b_hold_ch", alu_ch_b, 0);
        check("b_hold_op", alu_op_b, 0);
        alu_ready_b = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("b_ch%0d", k), alu_ch_b, k / 4);
            check($sformatf("b_op%0d", k), alu_op_b, k % 4);
            step();
        end
        check("b_pend_fs", frame_start_b, 1);
        check("b_pend_valid", alu_valid_b, 1);
        check("b_pend_ch", alu_ch_b, 0);
        check("b_pend_op", alu_op_b, 0);
        check("b_ovr_kept", overrun_b, 1);
        overrun_clr_b = 1'b1;
        step();
        check("b_ovr_clr", overrun_b, 0);
        overrun_clr_b = 1'b0;
        enable_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
